// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU that sits between register read and writeback.
// Single-cycle ops (add/sub/compare/logic/shift/illegal) finish on the accept
// edge. MUL (shift-add) and DIV/MOD (restoring division) run one bit per cycle.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (a, b, op latched on accept)
//   out_valid/out_ready result handshake
//   result, result_hi   primary result / MUL high word, DIV remainder, MOD quotient
//   flag_*              zero, carry/borrow, signed overflow, divide-by-zero, illegal op
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | waiting for an operation
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one dividend bit per cycle
// DONE  | result presented, waiting for out_ready
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [7:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_dz,
  output logic             flag_ill
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi;   // MUL: product high / DIV: partial remainder
  logic [WIDTH-1:0] acc_lo;   // MUL: multiplier shifting out / DIV: quotient shifting in
  logic [WIDTH-1:0] opnd;     // MUL: multiplicand / DIV: divisor
  logic             is_mod;

  assign in_ready = (state == S_IDLE) && !out_valid;

  // Single-cycle datapath, evaluated on the live inputs at the accept edge.
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [WIDTH-1:0] sc_res, sc_hi;
  logic             sc_carry, sc_ovf, sc_dz, sc_ill;
  logic             start_mul, start_div;

  always_comb begin
    sum_ext   = {1'b0, a} + {1'b0, b};
    diff_ext  = {1'b0, a} - {1'b0, b};
    sc_res    = '0;
    sc_hi     = '0;
    sc_carry  = 1'b0;
    sc_ovf    = 1'b0;
    sc_dz     = 1'b0;
    sc_ill    = 1'b0;
    start_mul = 1'b0;
    start_div = 1'b0;
    case (op)
      8'h00: begin
        sc_res   = sum_ext[WIDTH-1:0];
        sc_carry = sum_ext[WIDTH];
        sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      8'h01: begin
        sc_res   = diff_ext[WIDTH-1:0];
        sc_carry = diff_ext[WIDTH];   // borrow out is exactly a < b
        sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      8'h02: start_mul = 1'b1;
      8'h03: begin
        if (b == '0) begin
          sc_res = '1;
          sc_hi  = a;
          sc_dz  = 1'b1;
        end else begin
          start_div = 1'b1;
        end
      end
      8'h13: begin
        if (b == '0) begin
          sc_res = a;
          sc_hi  = '1;
          sc_dz  = 1'b1;
        end else begin
          start_div = 1'b1;
        end
      end
      8'h04: sc_res = WIDTH'(a == b);
      8'h05: sc_res = WIDTH'(a < b);
      8'h06: sc_res = WIDTH'(a > b);
      8'h08: sc_res = ~a;
      8'h09: sc_res = a & b;
      8'h0A: sc_res = a | b;
      8'h0B: sc_res = a ^ b;
      8'h10: sc_res = (b >= WIDTH'(WIDTH)) ? '0 : (a << b);
      8'h11: sc_res = (b >= WIDTH'(WIDTH)) ? '0 : (a >> b);
      default: sc_ill = 1'b1;
    endcase
  end

  // One shift-add step: conditionally add multiplicand to the high half,
  // then shift the whole 2*WIDTH accumulator right by one.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

  // One restoring-division step: shift the next dividend bit into the
  // remainder and keep the subtraction only if it did not go negative.
  logic [WIDTH:0]   div_shift, div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] rem_nx, quot_nx;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};

    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd};
    div_ok    = !div_trial[WIDTH];
    rem_nx    = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quot_nx   = {acc_lo[WIDTH-2:0], div_ok};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      opnd       <= '0;
      is_mod     <= 1'b0;
      out_valid  <= 1'b0;
      result     <= '0;
      result_hi  <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
      flag_dz    <= 1'b0;
      flag_ill   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            cnt    <= CNT_W'(WIDTH);
            is_mod <= op[4];
            if (start_mul) begin
              acc_hi <= '0;
              acc_lo <= b;
              opnd   <= a;
              state  <= S_MUL;
            end else if (start_div) begin
              acc_hi <= '0;
              acc_lo <= a;
              opnd   <= b;
              state  <= S_DIV;
            end else begin
              result     <= sc_res;
              result_hi  <= sc_hi;
              flag_zero  <= (sc_res == '0);
              flag_carry <= sc_carry;
              flag_ovf   <= sc_ovf;
              flag_dz    <= sc_dz;
              flag_ill   <= sc_ill;
              out_valid  <= 1'b1;
              state      <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc_hi <= mul_hi_nx;
          acc_lo <= mul_lo_nx;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            result     <= mul_lo_nx;
            result_hi  <= mul_hi_nx;
            flag_zero  <= (mul_lo_nx == '0);
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
            flag_dz    <= 1'b0;
            flag_ill   <= 1'b0;
            out_valid  <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DIV: begin
          acc_hi <= rem_nx;
          acc_lo <= quot_nx;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            result     <= is_mod ? rem_nx : quot_nx;
            result_hi  <= is_mod ? quot_nx : rem_nx;
            flag_zero  <= ((is_mod ? rem_nx : quot_nx) == '0);
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
            flag_dz    <= 1'b0;
            flag_ill   <= 1'b0;
            out_valid  <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  op = 8'h00;
  logic        out_ready = 1'b0;

  logic        in_valid8 = 1'b0, in_ready8, out_valid8;
  logic [7:0]  a8 = '0, b8 = '0, res8, hi8;
  logic        z8, c8, v8, d8, i8;

  logic        in_valid16 = 1'b0, in_ready16, out_valid16;
  logic [15:0] a16 = '0, b16 = '0, res16, hi16;
  logic        z16, c16, v16, d16, i16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op), .out_valid(out_valid8), .out_ready(out_ready),
    .result(res8), .result_hi(hi8), .flag_zero(z8), .flag_carry(c8),
    .flag_ovf(v8), .flag_dz(d8), .flag_ill(i8));

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op(op), .out_valid(out_valid16), .out_ready(out_ready),
    .result(res16), .result_hi(hi16), .flag_zero(z16), .flag_carry(c16),
    .flag_ovf(v16), .flag_dz(d16), .flag_ill(i16));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags packed as {ill, dz, ovf, carry, zero}.
  task automatic snap(input bit w16, output logic ov, output logic ir,
                      output logic [15:0] r, output logic [15:0] h, output logic [4:0] fl);
    if (w16) begin
      ov = out_valid16; ir = in_ready16; r = res16; h = hi16;
      fl = {i16, d16, v16, c16, z16};
    end else begin
      ov = out_valid8; ir = in_ready8; r = {8'h00, res8}; h = {8'h00, hi8};
      fl = {i8, d8, v8, c8, z8};
    end
  endtask

  // Behavioural reference: plain integer arithmetic on the opcode rules.
  function automatic void model(input int w, input logic [7:0] o, input longint a, input longint b,
                                output longint r, output longint h, output logic [4:0] fl,
                                output int lat);
    longint full, mask, half, sa, sb, s;
    logic carry, ovf, dz, ill;
    full = 64'sd1 << w; mask = full - 1; half = full / 2;
    sa = (a >= half) ? a - full : a;
    sb = (b >= half) ? b - full : b;
    r = 0; h = 0; carry = 0; ovf = 0; dz = 0; ill = 0; lat = 1;
    case (o)
      8'h00: begin r = (a + b) & mask; carry = (a + b) >= full;
                   s = sa + sb; ovf = (s < -half) || (s >= half); end
      8'h01: begin r = (a - b) & mask; carry = a < b;
                   s = sa - sb; ovf = (s < -half) || (s >= half); end
      8'h02: begin r = (a * b) & mask; h = (a * b) / full; lat = w + 1; end
      8'h03: if (b == 0) begin r = mask; h = a; dz = 1; end
             else begin r = a / b; h = a % b; lat = w + 1; end
      8'h13: if (b == 0) begin r = a; h = mask; dz = 1; end
             else begin r = a % b; h = a / b; lat = w + 1; end
      8'h04: r = (a == b) ? 1 : 0;
      8'h05: r = (a < b) ? 1 : 0;
      8'h06: r = (a > b) ? 1 : 0;
      8'h08: r = mask - a;
      8'h09: r = a & b;
      8'h0A: r = a | b;
      8'h0B: r = a ^ b;
      8'h10: r = (b >= w) ? 0 : ((a << b) & mask);
      8'h11: r = (b >= w) ? 0 : (a >> b);
      default: ill = 1;
    endcase
    fl = {ill, dz, ovf, carry, (r == 0)};
  endfunction

  // Issue one operation, wait for its result, optionally hold out_ready low
  // for `hold` cycles, then consume it. Operands are scrambled after accept.
  task automatic do_op(input bit w16, input logic [7:0] o, input logic [15:0] ai,
                       input logic [15:0] bi, input int hold, input string tag,
                       output logic [15:0] r, output logic [15:0] h, output logic [4:0] fl,
                       output int lat, output bit busy_ok, output bit stable_ok);
    logic ov, ir;
    logic [15:0] r2, h2;
    logic [4:0]  f2;
    int n;
    busy_ok = 1; stable_ok = 1;
    n = 0;
    snap(w16, ov, ir, r, h, fl);
    while (!ir && n < 100) begin
      @(posedge clk); #1; n++;
      snap(w16, ov, ir, r, h, fl);
    end
    if (!ir) check({tag, "_ready_timeout"}, 64'(ir), 64'd1);
    op = o;
    if (w16) begin a16 = ai; b16 = bi; in_valid16 = 1'b1; end
    else begin a8 = ai[7:0]; b8 = bi[7:0]; in_valid8 = 1'b1; end
    @(posedge clk); #1;
    in_valid8 = 1'b0; in_valid16 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
    op = 8'($urandom);
    n = 0;
    snap(w16, ov, ir, r, h, fl);
    while (!ov && n < 100) begin
      if (ir) busy_ok = 0;
      @(posedge clk); #1; n++;
      snap(w16, ov, ir, r, h, fl);
    end
    lat = n + 1;
    if (!ov) check({tag, "_valid_timeout"}, 64'(ov), 64'd1);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      snap(w16, ov, ir, r2, h2, f2);
      if (!ov || ir || r2 !== r || h2 !== h || f2 !== fl) stable_ok = 0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [15:0] r, h;
  logic [4:0]  fl;
  int          lat;
  bit          busy_ok, stable_ok;
  longint      er, eh;
  logic [4:0]  efl;
  int          elat;
  logic [7:0]  op_tab [14];
  bit          no_ov;

  initial begin
    op_tab[0] = 8'h00; op_tab[1] = 8'h01; op_tab[2] = 8'h02; op_tab[3] = 8'h03;
    op_tab[4] = 8'h13; op_tab[5] = 8'h04; op_tab[6] = 8'h05; op_tab[7] = 8'h06;
    op_tab[8] = 8'h08; op_tab[9] = 8'h09; op_tab[10] = 8'h0A; op_tab[11] = 8'h0B;
    op_tab[12] = 8'h10; op_tab[13] = 8'h11;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", 64'(in_ready8), 64'd1);
    check("rst_out_valid", 64'(out_valid8), 64'd0);
    check("rst_result", 64'(res8), 64'd0);
    check("rst_flags", 64'({i8, d8, v8, c8, z8}), 64'd0);

    do_op(0, 8'h00, 16'hFF, 16'h01, 0, "add_wrap", r, h, fl, lat, busy_ok, stable_ok);
    check("add_wrap_res", 64'(r), 64'h00);
    check("add_wrap_flags", 64'(fl), 64'b00011);
    check("add_wrap_lat", 64'(lat), 64'd1);

    do_op(0, 8'h00, 16'h7F, 16'h01, 0, "add_ovf", r, h, fl, lat, busy_ok, stable_ok);
    check("add_ovf_res", 64'(r), 64'h80);
    check("add_ovf_flags", 64'(fl), 64'b00100);

    // Reset in the middle of a multiply: nothing may come out.
    op = 8'h02; a8 = 8'h0F; b8 = 8'h0F; in_valid8 = 1'b1;
    @(posedge clk); #1 in_valid8 = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    no_ov = 1;
    for (int k = 0; k < 20; k++) begin
      if (out_valid8) no_ov = 0;
      @(posedge clk); #1;
    end
    check("rstmul_no_valid", 64'(no_ov), 64'd1);
    check("rstmul_in_ready", 64'(in_ready8), 64'd1);
    check("rstmul_result", 64'(res8), 64'd0);

    do_op(0, 8'h02, 16'hFF, 16'hFF, 0, "mul_ff", r, h, fl, lat, busy_ok, stable_ok);
    check("mul_ff_res", 64'(r), 64'h01);
    check("mul_ff_hi", 64'(h), 64'hFE);
    check("mul_ff_lat", 64'(lat), 64'd9);
    check("mul_ff_busy", 64'(busy_ok), 64'd1);

    do_op(0, 8'h03, 16'd200, 16'd7, 0, "div", r, h, fl, lat, busy_ok, stable_ok);
    check("div_q", 64'(r), 64'd28);
    check("div_r", 64'(h), 64'd4);
    check("div_lat", 64'(lat), 64'd9);

    do_op(0, 8'h13, 16'd200, 16'd7, 0, "mod", r, h, fl, lat, busy_ok, stable_ok);
    check("mod_res", 64'(r), 64'd4);
    check("mod_hi", 64'(h), 64'd28);

    do_op(0, 8'h03, 16'd5, 16'd0, 0, "div0", r, h, fl, lat, busy_ok, stable_ok);
    check("div0_res", 64'(r), 64'hFF);
    check("div0_hi", 64'(h), 64'h05);
    check("div0_flags", 64'(fl), 64'b01000);
    check("div0_lat", 64'(lat), 64'd1);

    do_op(0, 8'h10, 16'h81, 16'd1, 5, "shl_bp", r, h, fl, lat, busy_ok, stable_ok);
    check("shl_bp_res", 64'(r), 64'h02);
    check("shl_bp_stable", 64'(stable_ok), 64'd1);

    do_op(0, 8'h11, 16'h80, 16'd9, 0, "shr_big", r, h, fl, lat, busy_ok, stable_ok);
    check("shr_big_res", 64'(r), 64'h00);

    do_op(0, 8'h07, 16'h12, 16'h34, 0, "ill", r, h, fl, lat, busy_ok, stable_ok);
    check("ill_res", 64'(r), 64'h00);
    check("ill_flags", 64'(fl), 64'b10001);
    check("ill_lat", 64'(lat), 64'd1);

    do_op(1, 8'h02, 16'hFFFF, 16'h0002, 0, "mul16", r, h, fl, lat, busy_ok, stable_ok);
    check("mul16_res", 64'(r), 64'hFFFE);
    check("mul16_hi", 64'(h), 64'h0001);
    check("mul16_lat", 64'(lat), 64'd17);

    for (int t = 0; t < 3000; t++) begin
      bit w16;
      logic [7:0]  o;
      logic [15:0] ra, rb;
      int w;
      w16 = t[0];
      w = w16 ? 16 : 8;
      o = ($urandom_range(0, 9) == 0) ? 8'($urandom) : op_tab[$urandom_range(0, 13)];
      ra = 16'($urandom);
      case ($urandom_range(0, 5))
        0: rb = 16'd0;
        1: rb = 16'($urandom_range(0, 20));
        default: rb = 16'($urandom);
      endcase
      if (!w16) begin ra[15:8] = 8'h00; rb[15:8] = 8'h00; end
      model(w, o, longint'(ra), longint'(rb), er, eh, efl, elat);
      do_op(w16, o, ra, rb, 0, "rnd", r, h, fl, lat, busy_ok, stable_ok);
      check($sformatf("rnd_res w%0d op%0h a%0h b%0h", w, o, ra, rb), 64'(r), 64'(er));
      check($sformatf("rnd_hi w%0d op%0h a%0h b%0h", w, o, ra, rb), 64'(h), 64'(eh));
      check($sformatf("rnd_flags w%0d op%0h a%0h b%0h", w, o, ra, rb), 64'(fl), 64'(efl));
      check($sformatf("rnd_lat w%0d op%0h", w, o), 64'(lat), 64'(elat));
      check($sformatf("rnd_busy w%0d op%0h", w, o), 64'(busy_ok), 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
